// File: rtl/btb_pkg.sv
// Shared types and helpers for the branch target buffer: direction-counter
// encodings, PC index/tag slicing and the counter-update opcode.
package btb_pkg;

    typedef enum logic [1:0] {
        CTR_HOLD = 2'd0,
        CTR_INC  = 2'd1,
        CTR_DEC  = 2'd2
    } ctr_op_e;

    // Counter encodings are returned 4 bits wide (CTR_W is at most 4);
    // callers cast down to their own CTR_W.
    function automatic logic [3:0] ctr_wnt(input int ctr_w);
        return 4'((1 << (ctr_w - 1)) - 1);
    endfunction

    function automatic logic [3:0] ctr_wt(input int ctr_w);
        return 4'(1 << (ctr_w - 1));
    endfunction

    function automatic logic [3:0] ctr_max(input int ctr_w);
        return 4'((1 << ctr_w) - 1);
    endfunction

    // PCs are handled zero-extended to 64 bits; callers cast the result.
    function automatic logic [63:0] pc_index(input logic [63:0] pc, input int idx_w);
        return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int idx_w);
        return pc >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/btb_sat_counter.sv
// Combinational CTR_W-bit saturating counter step (hold / increment / decrement).
module btb_sat_counter
    import btb_pkg::*;
#(
    parameter int CTR_W = 2
) (
    input  ctr_op_e          op,
    input  logic [CTR_W-1:0] ctr,
    output logic [CTR_W-1:0] ctr_nxt
);

    localparam logic [CTR_W-1:0] MAX = CTR_W'(ctr_max(CTR_W));

    always_comb begin
        ctr_nxt = ctr;
        case (op)
            CTR_INC: if (ctr != MAX)             ctr_nxt = ctr + CTR_W'(1);
            CTR_DEC: if (ctr != {CTR_W{1'b0}})  ctr_nxt = ctr - CTR_W'(1);
            default: ctr_nxt = ctr;
        endcase
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with saturating direction counters; combinational lookup,
// trained from ID. Define BTB_STATS_EN to add the 32-bit perf counters.
module branch_target_buffer
    import btb_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              enable,
    input  logic [DATA_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [DATA_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [DATA_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [DATA_W-1:0] upd_target,
    input  logic              upd_mispredict,
    input  logic              flush_all
`ifdef BTB_STATS_EN
    ,
    output logic [31:0]       perf_lookups,
    output logic [31:0]       perf_updates,
    output logic [31:0]       perf_mispredicts
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = DATA_W - IDX_W - 2;
    localparam logic [CTR_W-1:0] WNT = CTR_W'(ctr_wnt(CTR_W));
    localparam logic [CTR_W-1:0] WT  = CTR_W'(ctr_wt(CTR_W));

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [CTR_W-1:0]  ctr;
        logic [DATA_W-1:0] target;
    } entry_t;

    localparam entry_t RST_ENTRY = '{valid: 1'b0, tag: '0, ctr: WNT, target: '0};

    entry_t tbl_q [ENTRIES];
    entry_t tbl_d [ENTRIES];

    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic [TAG_W-1:0] lk_tag, upd_tag;
    entry_t           lk_ent, upd_ent;
    logic             upd_hit;
    ctr_op_e          ctr_op;
    logic [CTR_W-1:0] ctr_nxt;

    assign lk_idx  = IDX_W'(pc_index(64'(lookup_pc), IDX_W));
    assign lk_tag  = TAG_W'(pc_tag(64'(lookup_pc), IDX_W));
    assign upd_idx = IDX_W'(pc_index(64'(upd_pc), IDX_W));
    assign upd_tag = TAG_W'(pc_tag(64'(upd_pc), IDX_W));

    // Lookup reads the registered table only, so a same-cycle update is not visible.
    assign lk_ent      = tbl_q[lk_idx];
    assign pred_hit    = lk_ent.valid && (lk_ent.tag == lk_tag);
    assign pred_taken  = pred_hit && lk_ent.ctr[CTR_W-1];
    assign pred_target = pred_hit ? lk_ent.target : '0;

    assign upd_ent = tbl_q[upd_idx];
    assign upd_hit = upd_ent.valid && (upd_ent.tag == upd_tag);

    always_comb begin
        ctr_op = CTR_HOLD;
        if (upd_hit) ctr_op = upd_taken ? CTR_INC : CTR_DEC;
    end

    btb_sat_counter #(.CTR_W(CTR_W)) u_ctr (
        .op      (ctr_op),
        .ctr     (upd_ent.ctr),
        .ctr_nxt (ctr_nxt)
    );

    always_comb begin
        tbl_d = tbl_q;
        if (enable && flush_all) begin
            // Flush only drops valid; counters and targets persist.
            for (int i = 0; i < ENTRIES; i++) tbl_d[i].valid = 1'b0;
        end else if (enable && upd_valid) begin
            if (upd_hit) begin
                tbl_d[upd_idx].ctr = ctr_nxt;
                if (upd_taken) tbl_d[upd_idx].target = upd_target;
            end else if (upd_taken) begin
                tbl_d[upd_idx] = '{valid: 1'b1, tag: upd_tag, ctr: WT, target: upd_target};
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= RST_ENTRY;
        end else begin
            for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= tbl_d[i];
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] perf_lookups_q, perf_lookups_d;
    logic [31:0] perf_updates_q, perf_updates_d;
    logic [31:0] perf_mispredicts_q, perf_mispredicts_d;

    always_comb begin
        perf_lookups_d     = perf_lookups_q;
        perf_updates_d     = perf_updates_q;
        perf_mispredicts_d = perf_mispredicts_q;
        if (enable) begin
            if (perf_lookups_q != 32'hFFFF_FFFF) perf_lookups_d = perf_lookups_q + 32'd1;
            if (upd_valid && perf_updates_q != 32'hFFFF_FFFF)
                perf_updates_d = perf_updates_q + 32'd1;
            if (upd_valid && upd_mispredict && perf_mispredicts_q != 32'hFFFF_FFFF)
                perf_mispredicts_d = perf_mispredicts_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            perf_lookups_q     <= '0;
            perf_updates_q     <= '0;
            perf_mispredicts_q <= '0;
        end else begin
            perf_lookups_q     <= perf_lookups_d;
            perf_updates_q     <= perf_updates_d;
            perf_mispredicts_q <= perf_mispredicts_d;
        end
    end

    assign perf_lookups     = perf_lookups_q;
    assign perf_updates     = perf_updates_q;
    assign perf_mispredicts = perf_mispredicts_q;
`else
    logic unused_mispredict;
    assign unused_mispredict = upd_mispredict;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed + randomized bench for branch_target_buffer against a table-level
// reference model (per-index records, integer counters).
module tb_branch_target_buffer;

    localparam int DATA_W  = 64;
    localparam int ENTRIES = 16;
    localparam int CTR_W   = 2;
    localparam int CMAX    = (1 << CTR_W) - 1;
    localparam int CHALF   = 1 << (CTR_W - 1);

    logic              clk = 1'b0;
    logic              arst;
    logic              enable;
    logic [DATA_W-1:0] lookup_pc;
    logic              pred_hit, pred_taken;
    logic [DATA_W-1:0] pred_target;
    logic              upd_valid;
    logic [DATA_W-1:0] upd_pc;
    logic              upd_taken;
    logic [DATA_W-1:0] upd_target;
    logic              upd_mispredict;
    logic              flush_all;
`ifdef BTB_STATS_EN
    logic [31:0] perf_lookups, perf_updates, perf_mispredicts;
`endif

    branch_target_buffer #(.DATA_W(DATA_W), .ENTRIES(ENTRIES), .CTR_W(CTR_W)) dut (
        .clk            (clk),
        .arst           (arst),
        .enable         (enable),
        .lookup_pc      (lookup_pc),
        .pred_hit       (pred_hit),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_mispredict (upd_mispredict),
        .flush_all      (flush_all)
`ifdef BTB_STATS_EN
        ,
        .perf_lookups     (perf_lookups),
        .perf_updates     (perf_updates),
        .perf_mispredicts (perf_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    // Reference model: one record per table slot.
    bit                 m_valid [ENTRIES];
    longint unsigned    m_tag   [ENTRIES];
    int                 m_ctr   [ENTRIES];
    logic [DATA_W-1:0]  m_tgt   [ENTRIES];
    longint unsigned    m_lookups, m_updates, m_misp;

    function automatic int midx(input logic [DATA_W-1:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic longint unsigned mtag(input logic [DATA_W-1:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_ctr[i] = CHALF - 1; m_tgt[i] = '0;
        end
        m_lookups = 0; m_updates = 0; m_misp = 0;
    endtask

    task automatic model_edge();
        int i;
        bit hit;
        if (!enable) return;
        m_lookups++;
        if (upd_valid) m_updates++;
        if (upd_valid && upd_mispredict) m_misp++;
        if (flush_all) begin
            for (int k = 0; k < ENTRIES; k++) m_valid[k] = 0;
            return;
        end
        if (!upd_valid) return;
        i   = midx(upd_pc);
        hit = m_valid[i] && (m_tag[i] == mtag(upd_pc));
        if (hit && upd_taken) begin
            m_ctr[i] = (m_ctr[i] < CMAX) ? m_ctr[i] + 1 : CMAX;
            m_tgt[i] = upd_target;
        end else if (hit) begin
            m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end else if (upd_taken) begin
            m_valid[i] = 1; m_tag[i] = mtag(upd_pc); m_ctr[i] = CHALF; m_tgt[i] = upd_target;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_model(input string tag);
        int  i;
        bit  hit;
        i   = midx(lookup_pc);
        hit = m_valid[i] && (m_tag[i] == mtag(lookup_pc));
        chk({tag, "_hit"}, 64'(pred_hit), 64'(hit));
        chk({tag, "_taken"}, 64'(pred_taken), 64'(hit && (m_ctr[i] >= CHALF)));
        chk({tag, "_target"}, 64'(pred_target), hit ? 64'(m_tgt[i]) : 64'd0);
`ifdef BTB_STATS_EN
        chk({tag, "_plk"}, 64'(perf_lookups), 64'(m_lookups));
        chk({tag, "_pupd"}, 64'(perf_updates), 64'(m_updates));
        chk({tag, "_pmis"}, 64'(perf_mispredicts), 64'(m_misp));
`endif
    endtask

    // One cycle: check combinational outputs mid-low-phase, clock, advance model.
    task automatic cyc(input string tag);
        #1;
        check_model(tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        enable = 1'b1; upd_valid = 1'b0; upd_taken = 1'b0; upd_mispredict = 1'b0;
        flush_all = 1'b0; upd_pc = '0; upd_target = '0;
    endtask

    task automatic train(input logic [63:0] pc, input bit taken, input logic [63:0] tgt);
        upd_valid = 1'b1; upd_pc = pc; upd_taken = taken; upd_target = tgt;
        cyc("train");
        idle();
    endtask

    task automatic look(input logic [63:0] pc, input bit e_hit, input bit e_tk,
                        input logic [63:0] e_tgt, input string tag);
        lookup_pc = pc;
        #1;
        chk({tag, "_hit"}, 64'(pred_hit), 64'(e_hit));
        chk({tag, "_taken"}, 64'(pred_taken), 64'(e_tk));
        chk({tag, "_target"}, 64'(pred_target), e_tgt);
        cyc(tag);
    endtask

    initial begin
        arst = 1'b1;
        idle();
        lookup_pc = 64'h100;
        model_reset();
        #1;
        chk("rst_hit", 64'(pred_hit), 64'd0);
        chk("rst_taken", 64'(pred_taken), 64'd0);
        chk("rst_target", 64'(pred_target), 64'd0);
        @(negedge clk); @(negedge clk);
        arst = 1'b0;

        // Allocate, then weaken to not-taken, then saturate.
        train(64'h100, 1'b1, 64'h180);
        look(64'h100, 1, 1, 64'h180, "alloc");
        train(64'h100, 1'b0, 64'h0);
        train(64'h100, 1'b0, 64'h0);
        look(64'h100, 1, 0, 64'h180, "dec2");
        for (int k = 0; k < 4; k++) train(64'h100, 1'b1, 64'h180);
        train(64'h100, 1'b0, 64'h0);
        look(64'h100, 1, 1, 64'h180, "sat");

        // Aliasing at index 0.
        train(64'h100, 1'b1, 64'h200);
        train(64'h140, 1'b1, 64'h300);
        look(64'h100, 0, 0, 64'h0, "alias_old");
        look(64'h140, 1, 1, 64'h300, "alias_new");

        // Same-cycle update and lookup: no bypass.
        lookup_pc = 64'h104;
        upd_valid = 1'b1; upd_pc = 64'h104; upd_taken = 1'b1; upd_target = 64'h444;
        #1;
        chk("nobyp_same", 64'(pred_hit), 64'd0);
        cyc("nobyp");
        idle();
        look(64'h104, 1, 1, 64'h444, "nobyp_next");

        // Stall drops the update.
        lookup_pc = 64'h10C;
        enable = 1'b0; upd_valid = 1'b1; upd_pc = 64'h10C; upd_taken = 1'b1; upd_target = 64'h555;
        cyc("stall");
        idle();
        look(64'h10C, 0, 0, 64'h0, "stall_next");

        // Flush beats a simultaneous update.
        flush_all = 1'b1; upd_valid = 1'b1; upd_pc = 64'h108; upd_taken = 1'b1; upd_target = 64'h666;
        cyc("flush");
        idle();
        look(64'h108, 0, 0, 64'h0, "flush_108");
        look(64'h140, 0, 0, 64'h0, "flush_140");
        look(64'h104, 0, 0, 64'h0, "flush_104");

        // Randomized traffic over a small aliasing-heavy PC pool.
        for (int n = 0; n < 600; n++) begin
            enable         = ($urandom_range(0, 9) != 0);
            flush_all      = ($urandom_range(0, 39) == 0);
            upd_valid      = ($urandom_range(0, 9) < 6);
            upd_taken      = ($urandom_range(0, 9) < 6);
            upd_mispredict = ($urandom_range(0, 9) < 3);
            upd_pc         = 64'({$urandom_range(0, 3), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))});
            upd_target     = {32'($urandom), 32'($urandom)};
            lookup_pc      = 64'({$urandom_range(0, 3), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))});
            cyc("rand");
        end
        idle();

        // Reset asserted mid-cycle with an update pending.
        train(64'h100, 1'b1, 64'h900);
        lookup_pc = 64'h100;
        upd_valid = 1'b1; upd_pc = 64'h104; upd_taken = 1'b1; upd_target = 64'h777;
        #2;
        arst = 1'b1;
        #1;
        chk("arst_hit", 64'(pred_hit), 64'd0);
        chk("arst_target", 64'(pred_target), 64'd0);
        @(posedge clk);
        @(negedge clk);
        model_reset();
        arst = 1'b0;
        idle();
        look(64'h104, 0, 0, 64'h0, "post_rst_104");
        look(64'h100, 0, 0, 64'h0, "post_rst_100");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
